mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The parameter list SHALL be exactly:
- TIMEOUT, default 64: maximum number of RD-state cycles before a read is abandoned.
- TO_BITS, default $clog2(TIMEOUT)+1: width of the timeout counter.

REQ-002 The ports SHALL be exactly as follows (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset: synchronous, active-low.
- fetch_ren  in  1  fetch read request; level, held until fetch_gnt.
- fetch_raddr  in  64  fetch read address; stable while fetch_ren is high.
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted.
- fetch_rvalid  out  1  fetch read data valid.
- fetch_rdata  out  64  fetch read data.
- lsu_ren  in  1  LSU read request; level, held until lsu_gnt.
- lsu_raddr  in  64  LSU read address.
- lsu_wen  in  1  LSU write request; level, held until lsu_gnt.
- lsu_waddr  in  64  LSU write address.
- lsu_wdata  in  64  LSU write data.
- lsu_gnt  out  1  one-cycle pulse: LSU read or write accepted.
- lsu_rvalid  out  1  LSU read data valid.
- lsu_rdata  out  64  LSU read data.
- mem_ren  out  1  memory read strobe; one cycle per read.
- mem_raddr  out  64  memory read address.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  64  memory read data.
- mem_wen  out  1  memory write strobe; one cycle per write.
- mem_waddr  out  64  memory write address.
- mem_wdata  out  64  memory write data.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a read is abandoned.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, RD_FETCH, RD_LSU, WR.

REQ-004 Requests SHALL be sampled in IDLE only; requests seen in any other state are ignored until the FSM returns to IDLE.

REQ-005 Arbitration in IDLE SHALL use this priority:
- lsu_wen first, even if lsu_ren is also high.
- Otherwise, between fetch_ren and lsu_ren, the requester indicated by a round-robin pointer.
- A lone requester is always selected.

REQ-006 The round-robin pointer SHALL update on each grant:
- A fetch grant makes LSU preferred next.
- An LSU grant (read or write) makes fetch preferred next.
- On reset, LSU is preferred.

REQ-007 When a request is selected in IDLE cycle N, at the edge ending N:
- The FSM enters WR, RD_FETCH or RD_LSU.
- The address, and for writes the data, are registered onto mem_raddr, or mem_waddr/mem_wdata.

REQ-008 In the first cycle (N+1) of a new state:
- The matching gnt SHALL be high for that cycle only.
- mem_ren SHALL be high for that cycle only in RD states.
- mem_wen SHALL be high for that cycle only in WR.

REQ-009 WR SHALL last exactly one cycle and then return to IDLE.

REQ-010 mem_raddr, mem_waddr and mem_wdata SHALL hold their registered values until the next grant.

REQ-011 In RD_x, mem_rvalid SHALL be sampled in every cycle after the first. On the first sampled mem_rvalid:
- x_rvalid=1 in that same cycle.
- x_rdata=mem_rdata combinationally.
- The FSM returns to IDLE at the next edge.

REQ-012 fetch_rdata and lsu_rdata SHALL always equal mem_rdata; the rvalid signals qualify them.

REQ-013 mem_rvalid SHALL be ignored in IDLE, in WR, and in the first cycle of an RD state.

REQ-014 The timeout counter SHALL clear on entry to an RD state and increment in each RD cycle. If it reaches TIMEOUT-1 without mem_rvalid:
- timeout_err=1 for that cycle.
- The FSM returns to IDLE.
- No rvalid is issued to the requester.

REQ-015 Minimum latencies SHALL be:
- Request to grant: 1 cycle.
- Request to rvalid: 2 cycles.
- Back-to-back write throughput: one write per 2 cycles.

REQ-016 A requester that keeps its request high after its gnt cycle SHALL be treated as issuing a new request.

Reset
REQ-017 With rst=0 at a rising edge:
- The FSM SHALL enter IDLE and the pointer SHALL prefer LSU.
- The timeout counter SHALL clear.
- All 1-bit outputs SHALL be 0.
- mem_raddr, mem_waddr and mem_wdata SHALL be 0.

REQ-018 A reset during RD or WR SHALL abort the transaction. No gnt or rvalid is issued for it, and a mem_rvalid arriving afterwards is ignored.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Fetch-only read: fetch_ren=1, addr 0x1000 at N; mem_rvalid with data 0xAB at N+3 -> fetch_gnt and mem_ren at N+1 with mem_raddr=0x1000, fetch_rvalid=1 and fetch_rdata=0xAB at N+3, busy low at N+4.
- Simultaneous reads after reset: fetch and LSU both request -> LSU granted first, fetch granted on the first IDLE cycle after the LSU rvalid.
- Write priority: lsu_wen=1, lsu_ren=1 and fetch_ren=1 together -> mem_wen=1 with waddr/wdata driven at N+1, then fetch read granted at N+3 (pointer now prefers fetch).
- Timeout: read issued, mem_rvalid never asserted -> timeout_err pulse in the TIMEOUT-th RD cycle, no rvalid, IDLE the next cycle; a later stray mem_rvalid produces no rvalid.
- Reset mid-read: rst=0 one cycle into RD_LSU -> all outputs 0 next cycle; a mem_rvalid after reset is ignored.
- mem_rvalid asserted in the mem_ren cycle -> ignored; the read completes on the next mem_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch/LSU request ports, the memory port and the arbiter status lines.
// Requests are levels held until the matching one-cycle gnt; rvalid qualifies rdata for one cycle.
interface mem_port_arbiter_if;
    logic        fetch_ren;
    logic [63:0] fetch_raddr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [63:0] fetch_rdata;
    logic        lsu_ren;
    logic [63:0] lsu_raddr;
    logic        lsu_wen;
    logic [63:0] lsu_waddr;
    logic [63:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  fetch_ren, fetch_raddr, lsu_ren, lsu_raddr, lsu_wen, lsu_waddr, lsu_wdata,
               mem_rvalid, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
               mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, busy, timeout_err
    );

    modport master (
        output fetch_ren, fetch_raddr, lsu_ren, lsu_raddr, lsu_wen, lsu_waddr, lsu_wdata,
               mem_rvalid, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
               mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, busy, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch read port and an LSU read/write port onto one memory port.
// LSU writes win outright; competing reads alternate via a round-robin pointer.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TO_BITS = $clog2(TIMEOUT) + 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD_FETCH, RD_LSU, WR} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_lsu_pref;
    logic [TO_BITS-1:0] r_cnt;
    logic [63:0]        r_raddr;
    logic [63:0]        r_waddr;
    logic [63:0]        r_wdata;

    logic w_pick_wr;
    logic w_pick_lsu_rd;
    logic w_pick_fetch_rd;
    logic w_in_rd;
    logic w_first;
    logic w_sample;
    logic w_expire;

    assign w_pick_wr       = bus.lsu_wen;
    assign w_pick_lsu_rd   = !bus.lsu_wen && bus.lsu_ren && (r_lsu_pref || !bus.fetch_ren);
    assign w_pick_fetch_rd = !bus.lsu_wen && bus.fetch_ren && (!r_lsu_pref || !bus.lsu_ren);

    // The counter is zero only in the first RD cycle, which doubles as the grant/strobe cycle.
    assign w_in_rd  = (r_state == RD_FETCH) || (r_state == RD_LSU);
    assign w_first  = (r_cnt == '0);
    assign w_sample = w_in_rd && !w_first && bus.mem_rvalid;
    assign w_expire = w_in_rd && !w_sample && (r_cnt == TO_BITS'(TIMEOUT - 1));

    assign bus.fetch_rdata = bus.mem_rdata;
    assign bus.lsu_rdata   = bus.mem_rdata;
    assign bus.mem_raddr   = r_raddr;
    assign bus.mem_waddr   = r_waddr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.busy        = (r_state != IDLE);

    always_comb begin
        w_next           = r_state;
        bus.fetch_gnt    = 1'b0;
        bus.fetch_rvalid = 1'b0;
        bus.lsu_gnt      = 1'b0;
        bus.lsu_rvalid   = 1'b0;
        bus.mem_ren      = 1'b0;
        bus.mem_wen      = 1'b0;
        bus.timeout_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_wr)            w_next = WR;
                else if (w_pick_lsu_rd)   w_next = RD_LSU;
                else if (w_pick_fetch_rd) w_next = RD_FETCH;
            end
            RD_FETCH: begin
                bus.fetch_gnt    = w_first;
                bus.mem_ren      = w_first;
                bus.fetch_rvalid = w_sample;
                bus.timeout_err  = w_expire;
                if (w_sample || w_expire) w_next = IDLE;
            end
            RD_LSU: begin
                bus.lsu_gnt     = w_first;
                bus.mem_ren     = w_first;
                bus.lsu_rvalid  = w_sample;
                bus.timeout_err = w_expire;
                if (w_sample || w_expire) w_next = IDLE;
            end
            WR: begin
                bus.lsu_gnt = 1'b1;
                bus.mem_wen = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_lsu_pref <= 1'b1;
            r_cnt      <= '0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_pick_wr) begin
                    r_waddr    <= bus.lsu_waddr;
                    r_wdata    <= bus.lsu_wdata;
                    r_lsu_pref <= 1'b0;
                end else if (w_pick_lsu_rd) begin
                    r_raddr    <= bus.lsu_raddr;
                    r_lsu_pref <= 1'b0;
                end else if (w_pick_fetch_rd) begin
                    r_raddr    <= bus.fetch_raddr;
                    r_lsu_pref <= 1'b1;
                end
            end else if (w_in_rd) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after posedge,
// outputs are compared on the following negedge.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end of test");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.fetch_ren   = 1'b0;
        bus.fetch_raddr = '0;
        bus.lsu_ren     = 1'b0;
        bus.lsu_raddr   = '0;
        bus.lsu_wen     = 1'b0;
        bus.lsu_waddr   = '0;
        bus.lsu_wdata   = '0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic test_reset();
        logic [10:0] flags;
        rst = 1'b0;
        step();
        step();
        settle();
        flags = {bus.fetch_gnt, bus.fetch_rvalid, bus.lsu_gnt, bus.lsu_rvalid, bus.mem_ren,
                 bus.mem_wen, bus.busy, bus.timeout_err, 3'b000};
        n_checks++;
        if (flags !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0", flags);
        end
        n_checks++;
        if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wdata} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h %h %h want 0", bus.mem_raddr, bus.mem_waddr, bus.mem_wdata);
        end
        step();
        rst = 1'b1;
        settle();
    endtask

    task automatic test_simultaneous();
        step();
        bus.fetch_ren = 1'b1; bus.fetch_raddr = 64'h2000;
        bus.lsu_ren   = 1'b1; bus.lsu_raddr   = 64'h3000;
        settle();
        step(); settle();
        n_checks++;
        if ({bus.lsu_gnt, bus.fetch_gnt, bus.mem_ren} !== 3'b101 || bus.mem_raddr !== 64'h3000) begin
            n_fail++;
            $display("FAIL sim_lsu_first: got gnt l/f/ren=%b%b%b addr=%h want 101 3000",
                     bus.lsu_gnt, bus.fetch_gnt, bus.mem_ren, bus.mem_raddr);
        end
        bus.lsu_ren = 1'b0;
        step(); settle();
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h55;
        settle();
        n_checks++;
        if ({bus.lsu_rvalid, bus.fetch_rvalid} !== 2'b10 || bus.lsu_rdata !== 64'h55) begin
            n_fail++;
            $display("FAIL sim_lsu_rvalid: got rv l/f=%b%b data=%h want 10 55",
                     bus.lsu_rvalid, bus.fetch_rvalid, bus.lsu_rdata);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        n_checks++;
        if ({bus.busy, bus.fetch_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL sim_idle_gap: got busy/fgnt=%b%b want 00", bus.busy, bus.fetch_gnt);
        end
        step(); settle();
        n_checks++;
        if ({bus.fetch_gnt, bus.mem_ren} !== 2'b11 || bus.mem_raddr !== 64'h2000) begin
            n_fail++;
            $display("FAIL sim_fetch_second: got gnt/ren=%b%b addr=%h want 11 2000",
                     bus.fetch_gnt, bus.mem_ren, bus.mem_raddr);
        end
        bus.fetch_ren = 1'b0;
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h66;
        settle();
        n_checks++;
        if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 64'h66) begin
            n_fail++;
            $display("FAIL sim_fetch_rvalid: got rv=%b data=%h want 1 66", bus.fetch_rvalid, bus.fetch_rdata);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
    endtask

    task automatic test_fetch_only();
        step();
        bus.fetch_ren = 1'b1; bus.fetch_raddr = 64'h1000;
        settle();
        step(); settle();
        n_checks++;
        if ({bus.fetch_gnt, bus.mem_ren, bus.lsu_gnt, bus.busy} !== 4'b1101 || bus.mem_raddr !== 64'h1000) begin
            n_fail++;
            $display("FAIL fetch_grant: got gnt/ren/lgnt/busy=%b%b%b%b addr=%h want 1101 1000",
                     bus.fetch_gnt, bus.mem_ren, bus.lsu_gnt, bus.busy, bus.mem_raddr);
        end
        bus.fetch_ren = 1'b0;
        step(); settle();
        n_checks++;
        if ({bus.fetch_gnt, bus.mem_ren, bus.fetch_rvalid, bus.busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL fetch_wait: got gnt/ren/rv/busy=%b%b%b%b want 0001",
                     bus.fetch_gnt, bus.mem_ren, bus.fetch_rvalid, bus.busy);
        end
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hAB;
        settle();
        n_checks++;
        if ({bus.fetch_rvalid, bus.lsu_rvalid} !== 2'b10 || bus.fetch_rdata !== 64'hAB) begin
            n_fail++;
            $display("FAIL fetch_rvalid: got rv f/l=%b%b data=%h want 10 ab",
                     bus.fetch_rvalid, bus.lsu_rvalid, bus.fetch_rdata);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        n_checks++;
        if ({bus.busy, bus.fetch_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_done: got busy/rv=%b%b want 00", bus.busy, bus.fetch_rvalid);
        end
    endtask

    task automatic test_write_priority();
        step();
        bus.lsu_wen   = 1'b1; bus.lsu_waddr   = 64'h4000; bus.lsu_wdata = 64'hDEAD;
        bus.lsu_ren   = 1'b1; bus.lsu_raddr   = 64'h5000;
        bus.fetch_ren = 1'b1; bus.fetch_raddr = 64'h6000;
        settle();
        step(); settle();
        n_checks++;
        if ({bus.mem_wen, bus.lsu_gnt, bus.mem_ren, bus.fetch_gnt, bus.busy} !== 5'b11001 ||
            bus.mem_waddr !== 64'h4000 || bus.mem_wdata !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL wr_first: got wen/lgnt/ren/fgnt/busy=%b%b%b%b%b waddr=%h wdata=%h want 11001 4000 dead",
                     bus.mem_wen, bus.lsu_gnt, bus.mem_ren, bus.fetch_gnt, bus.busy, bus.mem_waddr, bus.mem_wdata);
        end
        bus.lsu_wen = 1'b0;
        step(); settle();
        n_checks++;
        if ({bus.mem_wen, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_one_cycle: got wen/busy=%b%b want 00", bus.mem_wen, bus.busy);
        end
        step(); settle();
        n_checks++;
        if ({bus.fetch_gnt, bus.lsu_gnt, bus.mem_ren} !== 3'b101 || bus.mem_raddr !== 64'h6000 ||
            bus.mem_waddr !== 64'h4000) begin
            n_fail++;
            $display("FAIL wr_then_fetch: got f/l/ren=%b%b%b raddr=%h waddr=%h want 101 6000 4000",
                     bus.fetch_gnt, bus.lsu_gnt, bus.mem_ren, bus.mem_raddr, bus.mem_waddr);
        end
        bus.fetch_ren = 1'b0;
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h33;
        settle();
        n_checks++;
        if ({bus.fetch_rvalid, bus.lsu_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_fetch_rvalid: got f/l=%b%b want 10", bus.fetch_rvalid, bus.lsu_rvalid);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        step(); settle();
        n_checks++;
        if (bus.lsu_gnt !== 1'b1 || bus.mem_raddr !== 64'h5000) begin
            n_fail++;
            $display("FAIL wr_lsu_last: got lgnt=%b addr=%h want 1 5000", bus.lsu_gnt, bus.mem_raddr);
        end
        bus.lsu_ren = 1'b0;
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h44;
        settle();
        n_checks++;
        if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 64'h44) begin
            n_fail++;
            $display("FAIL wr_lsu_rvalid: got rv=%b data=%h want 1 44", bus.lsu_rvalid, bus.lsu_rdata);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
    endtask

    task automatic test_early_rvalid();
        step();
        bus.lsu_ren = 1'b1; bus.lsu_raddr = 64'hA000;
        settle();
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h11;
        settle();
        n_checks++;
        if ({bus.lsu_gnt, bus.mem_ren, bus.lsu_rvalid} !== 3'b110) begin
            n_fail++;
            $display("FAIL early_ignored: got gnt/ren/rv=%b%b%b want 110", bus.lsu_gnt, bus.mem_ren, bus.lsu_rvalid);
        end
        bus.lsu_ren = 1'b0;
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        n_checks++;
        if ({bus.lsu_rvalid, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL early_still_busy: got rv/busy=%b%b want 01", bus.lsu_rvalid, bus.busy);
        end
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h22;
        settle();
        n_checks++;
        if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 64'h22) begin
            n_fail++;
            $display("FAIL early_completes: got rv=%b data=%h want 1 22", bus.lsu_rvalid, bus.lsu_rdata);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] exp;
        step();
        bus.fetch_ren = 1'b1; bus.fetch_raddr = 64'h8000;
        settle();
        for (int k = 1; k <= TO; k++) begin
            step(); settle();
            if (k == 1) bus.fetch_ren = 1'b0;
            exp = {(k == TO), 1'b0, 1'b1};
            n_checks++;
            if ({bus.timeout_err, bus.fetch_rvalid, bus.busy} !== exp) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got err/rv/busy=%b%b%b want %b",
                         k, bus.timeout_err, bus.fetch_rvalid, bus.busy, exp);
            end
        end
        step(); settle();
        n_checks++;
        if ({bus.timeout_err, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_idle: got err/busy=%b%b want 00", bus.timeout_err, bus.busy);
        end
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
        settle();
        n_checks++;
        if ({bus.fetch_rvalid, bus.lsu_rvalid, bus.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_stray: got f/l/busy=%b%b%b want 000", bus.fetch_rvalid, bus.lsu_rvalid, bus.busy);
        end
        step();
        bus.mem_rvalid = 1'b0;
        settle();
    endtask

    task automatic test_back_to_back();
        step();
        bus.lsu_wen = 1'b1; bus.lsu_waddr = 64'h7000; bus.lsu_wdata = 64'h70;
        settle();
        step(); settle();
        n_checks++;
        if ({bus.mem_wen, bus.lsu_gnt} !== 2'b11 || bus.mem_waddr !== 64'h7000 || bus.mem_wdata !== 64'h70) begin
            n_fail++;
            $display("FAIL b2b_first: got wen/gnt=%b%b waddr=%h wdata=%h want 11 7000 70",
                     bus.mem_wen, bus.lsu_gnt, bus.mem_waddr, bus.mem_wdata);
        end
        bus.lsu_waddr = 64'h7100; bus.lsu_wdata = 64'h71;
        step(); settle();
        n_checks++;
        if ({bus.mem_wen, bus.busy} !== 2'b00 || bus.mem_waddr !== 64'h7000) begin
            n_fail++;
            $display("FAIL b2b_gap: got wen/busy=%b%b waddr=%h want 00 7000", bus.mem_wen, bus.busy, bus.mem_waddr);
        end
        step(); settle();
        n_checks++;
        if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 64'h7100 || bus.mem_wdata !== 64'h71) begin
            n_fail++;
            $display("FAIL b2b_second: got wen=%b waddr=%h wdata=%h want 1 7100 71",
                     bus.mem_wen, bus.mem_waddr, bus.mem_wdata);
        end
        bus.lsu_wen = 1'b0;
        step(); settle();
        n_checks++;
        if ({bus.mem_wen, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got wen/busy=%b%b want 00", bus.mem_wen, bus.busy);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] flags;
        step();
        bus.lsu_ren = 1'b1; bus.lsu_raddr = 64'h9000;
        settle();
        step(); settle();
        n_checks++;
        if (bus.lsu_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rmr_grant: got lgnt=%b want 1", bus.lsu_gnt);
        end
        bus.lsu_ren = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        settle();
        flags = {bus.fetch_gnt, bus.fetch_rvalid, bus.lsu_gnt, bus.lsu_rvalid, bus.mem_ren,
                 bus.mem_wen, bus.busy, bus.timeout_err};
        n_checks++;
        if (flags !== 8'd0 || {bus.mem_raddr, bus.mem_waddr, bus.mem_wdata} !== 192'd0) begin
            n_fail++;
            $display("FAIL rmr_cleared: got flags=%b raddr=%h waddr=%h wdata=%h want 0",
                     flags, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata);
        end
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h99;
        settle();
        n_checks++;
        if ({bus.lsu_rvalid, bus.fetch_rvalid, bus.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmr_stray: got l/f/busy=%b%b%b want 000", bus.lsu_rvalid, bus.fetch_rvalid, bus.busy);
        end
        step();
        bus.mem_rvalid = 1'b0;
        bus.fetch_ren = 1'b1; bus.fetch_raddr = 64'hB000;
        bus.lsu_ren   = 1'b1; bus.lsu_raddr   = 64'hC000;
        settle();
        step(); settle();
        n_checks++;
        if ({bus.lsu_gnt, bus.fetch_gnt} !== 2'b10 || bus.mem_raddr !== 64'hC000) begin
            n_fail++;
            $display("FAIL rmr_ptr_lsu: got l/f=%b%b addr=%h want 10 c000", bus.lsu_gnt, bus.fetch_gnt, bus.mem_raddr);
        end
        clear_inputs();
        step();
        bus.mem_rvalid = 1'b1;
        settle();
        step();
        bus.mem_rvalid = 1'b0;
        settle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_simultaneous();
        test_fetch_only();
        test_write_priority();
        test_early_rvalid();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
